// File: rtl/bnn_mem_pkg.sv
// Shared X-memory widths, arbiter state encoding and requester IDs for the BNN activation
// scratchpad.
package bnn_mem_pkg;

  localparam int unsigned DEF_X_ADDR_LEN = 10;
  localparam int unsigned DEF_X_DATA_LEN = 1;
  localparam int unsigned DEF_X_SEL_LEN  = 2;
  localparam int unsigned DEF_MAX_WAIT   = 64;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_OWN_H      = 3'd1;
  localparam logic [2:0] ST_OWN_E      = 3'd2;
  localparam logic [2:0] ST_WR_PRESET  = 3'd3;
  localparam logic [2:0] ST_WR_STROBE  = 3'd4;
  localparam logic [2:0] ST_WR_FINISH  = 3'd5;
  localparam logic [2:0] ST_RD_CAPTURE = 3'd6;

  typedef enum logic [2:0] {
    StIdle      = ST_IDLE,
    StOwnH      = ST_OWN_H,
    StOwnE      = ST_OWN_E,
    StWrPreset  = ST_WR_PRESET,
    StWrStrobe  = ST_WR_STROBE,
    StWrFinish  = ST_WR_FINISH,
    StRdCapture = ST_RD_CAPTURE
  } xarb_state_e;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_ENG  = 1'b1;

  // True while a memory access sequence is in flight.
  function automatic logic is_seq(xarb_state_e s);
    return (s == StWrPreset) || (s == StWrStrobe) || (s == StWrFinish) ||
           (s == StRdCapture);
  endfunction

endpackage

// File: rtl/xarb_starve_ctr.sv
// Saturating count of cycles the host has waited for the X port; hit flags saturation.
module xarb_starve_ctr #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] cnt_q;

  assign hit = (cnt_q == CntW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !hit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/xmem_port_arbiter.sv
// Host/engine arbiter for the single-port X scratchpad with burst grants and a host starvation
// guard. Optional grant/conflict statistics are built when XARB_STATS_EN is defined.
module xmem_port_arbiter
  import bnn_mem_pkg::*;
#(
  parameter int unsigned X_ADDR_LEN = DEF_X_ADDR_LEN,
  parameter int unsigned X_DATA_LEN = DEF_X_DATA_LEN,
  parameter int unsigned X_SEL_LEN  = DEF_X_SEL_LEN,
  parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_req,
  output logic                  host_gnt,
  input  logic                  host_acc,
  input  logic                  host_we,
  input  logic [X_ADDR_LEN-1:0] host_addr,
  input  logic [X_SEL_LEN-1:0]  host_sel,
  input  logic [X_DATA_LEN-1:0] host_wdata,
  output logic                  host_done,
  output logic [X_DATA_LEN-1:0] host_rdata,
  input  logic                  eng_req,
  output logic                  eng_gnt,
  input  logic                  eng_acc,
  input  logic                  eng_we,
  input  logic [X_ADDR_LEN-1:0] eng_addr,
  input  logic [X_SEL_LEN-1:0]  eng_sel,
  input  logic [X_DATA_LEN-1:0] eng_wdata,
  output logic                  eng_done,
  output logic [X_DATA_LEN-1:0] eng_rdata,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic [X_SEL_LEN-1:0]  x_sel,
  output logic [X_DATA_LEN-1:0] x_wdata,
  output logic                  x_wq,
  input  logic [X_DATA_LEN-1:0] x_rdata,
  output logic                  busy
`ifdef XARB_STATS_EN
  ,
  output logic [15:0]           stat_host_gnts,
  output logic [15:0]           stat_eng_gnts,
  output logic [15:0]           stat_conflicts
`endif
);

  xarb_state_e state_q, state_d;

  logic                  owner_q;
  logic [X_ADDR_LEN-1:0] x_addr_q;
  logic [X_SEL_LEN-1:0]  x_sel_q;
  logic [X_DATA_LEN-1:0] x_wdata_q;
  logic                  rd_done_q;
  logic [X_DATA_LEN-1:0] host_rdata_q, eng_rdata_q;

  logic in_seq, host_accept, eng_accept, wr_done, seq_done;
  logic starve_inc, starve_clr, starve_hit;
  logic host_win, eng_win;

  assign in_seq      = is_seq(state_q);
  assign host_gnt    = (state_q == StOwnH) || (in_seq && owner_q == REQ_HOST);
  assign eng_gnt     = (state_q == StOwnE) || (in_seq && owner_q == REQ_ENG);
  assign host_accept = (state_q == StOwnH) && host_req && host_acc;
  assign eng_accept  = (state_q == StOwnE) && eng_req && eng_acc;

  assign wr_done    = (state_q == StWrFinish);
  assign seq_done   = wr_done || rd_done_q;
  assign host_done  = seq_done && (owner_q == REQ_HOST);
  assign eng_done   = seq_done && (owner_q == REQ_ENG);
  assign host_rdata = host_rdata_q;
  assign eng_rdata  = eng_rdata_q;

  assign x_addr  = x_addr_q;
  assign x_sel   = x_sel_q;
  assign x_wdata = x_wdata_q;
  assign x_wq    = (state_q == StWrStrobe);
  assign busy    = (state_q != StIdle);

  assign host_win   = (state_q == StIdle) && (state_d == StOwnH);
  assign eng_win    = (state_q == StIdle) && (state_d == StOwnE);
  assign starve_inc = host_req && !host_gnt;
  assign starve_clr = host_win;

  xarb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .hit (starve_hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (host_req && eng_req) begin
          state_d = starve_hit ? StOwnH : StOwnE;
        end else if (eng_req) begin
          state_d = StOwnE;
        end else if (host_req) begin
          state_d = StOwnH;
        end
      end
      StOwnH: begin
        if (!host_req) begin
          state_d = StIdle;
        end else if (host_acc) begin
          state_d = host_we ? StWrPreset : StRdCapture;
        end
      end
      StOwnE: begin
        if (!eng_req) begin
          state_d = StIdle;
        end else if (eng_acc) begin
          state_d = eng_we ? StWrPreset : StRdCapture;
        end
      end
      StWrPreset:  state_d = StWrStrobe;
      StWrStrobe:  state_d = StWrFinish;
      StWrFinish:  state_d = (owner_q == REQ_HOST) ? StOwnH : StOwnE;
      StRdCapture: state_d = (owner_q == REQ_HOST) ? StOwnH : StOwnE;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= REQ_HOST;
      x_addr_q     <= '0;
      x_sel_q      <= '0;
      x_wdata_q    <= '0;
      rd_done_q    <= 1'b0;
      host_rdata_q <= '0;
      eng_rdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_done_q <= (state_q == StRdCapture);
      if (host_accept) begin
        owner_q   <= REQ_HOST;
        x_addr_q  <= host_addr;
        x_sel_q   <= host_sel;
        x_wdata_q <= host_wdata;
      end else if (eng_accept) begin
        owner_q   <= REQ_ENG;
        x_addr_q  <= eng_addr;
        x_sel_q   <= eng_sel;
        x_wdata_q <= eng_wdata;
      end
      // x_rdata is expected to settle within the address cycle.
      if (state_q == StRdCapture) begin
        if (owner_q == REQ_HOST) begin
          host_rdata_q <= x_rdata;
        end else begin
          eng_rdata_q <= x_rdata;
        end
      end
    end
  end

`ifdef XARB_STATS_EN
  logic [15:0] host_gnts_q, eng_gnts_q, conflicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      host_gnts_q <= '0;
      eng_gnts_q  <= '0;
      conflicts_q <= '0;
    end else begin
      if (host_win && host_gnts_q != 16'hFFFF) host_gnts_q <= host_gnts_q + 16'd1;
      if (eng_win && eng_gnts_q != 16'hFFFF) eng_gnts_q <= eng_gnts_q + 16'd1;
      if ((state_q == StIdle) && host_req && eng_req && conflicts_q != 16'hFFFF) begin
        conflicts_q <= conflicts_q + 16'd1;
      end
    end
  end

  assign stat_host_gnts = host_gnts_q;
  assign stat_eng_gnts  = eng_gnts_q;
  assign stat_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_xmem_port_arbiter.sv
// Directed bench for xmem_port_arbiter with a behavioural X memory; statistics checks only
// when XARB_STATS_EN is defined.
module tb_xmem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_req = 0, host_acc = 0, host_we = 0;
  logic [9:0] host_addr = '0;
  logic [1:0] host_sel = '0;
  logic [0:0] host_wdata = '0;
  logic       host_gnt, host_done;
  logic [0:0] host_rdata;
  logic       eng_req = 0, eng_acc = 0, eng_we = 0;
  logic [9:0] eng_addr = '0;
  logic [1:0] eng_sel = '0;
  logic [0:0] eng_wdata = '0;
  logic       eng_gnt, eng_done;
  logic [0:0] eng_rdata;
  logic [9:0] x_addr;
  logic [1:0] x_sel;
  logic [0:0] x_wdata, x_rdata;
  logic       x_wq, busy;
`ifdef XARB_STATS_EN
  logic [15:0] stat_host_gnts, stat_eng_gnts, stat_conflicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int wq_cnt  = 0;
  int w0;

  bit mem [0:3][0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (x_wq) begin
      mem[x_sel][x_addr] <= x_wdata[0];
      wq_cnt <= wq_cnt + 1;
    end
  end

  assign x_rdata = mem[x_sel][x_addr];

  xmem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .host_req   (host_req),
    .host_gnt   (host_gnt),
    .host_acc   (host_acc),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_sel   (host_sel),
    .host_wdata (host_wdata),
    .host_done  (host_done),
    .host_rdata (host_rdata),
    .eng_req    (eng_req),
    .eng_gnt    (eng_gnt),
    .eng_acc    (eng_acc),
    .eng_we     (eng_we),
    .eng_addr   (eng_addr),
    .eng_sel    (eng_sel),
    .eng_wdata  (eng_wdata),
    .eng_done   (eng_done),
    .eng_rdata  (eng_rdata),
    .x_addr     (x_addr),
    .x_sel      (x_sel),
    .x_wdata    (x_wdata),
    .x_wq       (x_wq),
    .x_rdata    (x_rdata),
    .busy       (busy)
`ifdef XARB_STATS_EN
    ,
    .stat_host_gnts (stat_host_gnts),
    .stat_eng_gnts  (stat_eng_gnts),
    .stat_conflicts (stat_conflicts)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if ({host_gnt, eng_gnt, host_done, eng_done, x_wq, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000000",
               {host_gnt, eng_gnt, host_done, eng_done, x_wq, busy});
    end
    n_tests++;
    if ({x_addr, x_sel, x_wdata, host_rdata, eng_rdata} !== 15'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {x_addr, x_sel, x_wdata, host_rdata, eng_rdata});
    end
    n_tests++;
    if (dut.u_starve_ctr.cnt_q !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", dut.u_starve_ctr.cnt_q);
    end
    rst = 1'b0;
  endtask

  task automatic test_host_write();
    host_req = 1'b1;
    step();
    n_tests++;
    if (host_gnt !== 1'b1) begin
      n_fail++; $display("FAIL hw_gnt: got %b want 1", host_gnt);
    end
    host_acc = 1'b1; host_we = 1'b1; host_addr = 10'd5; host_sel = 2'd0; host_wdata = 1'b1;
    w0 = wq_cnt;
    step();
    host_acc = 1'b0;
    n_tests++;
    if ({x_wq, host_done, x_addr, x_sel, x_wdata} !== {1'b0, 1'b0, 10'd5, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL hw_preset: got wq=%b done=%b addr=%0d sel=%0d wd=%b want 0 0 5 0 1",
               x_wq, host_done, x_addr, x_sel, x_wdata);
    end
    step();
    n_tests++;
    if ({x_wq, host_done} !== 2'b10) begin
      n_fail++; $display("FAIL hw_strobe: got wq=%b done=%b want 1 0", x_wq, host_done);
    end
    step();
    n_tests++;
    if ({x_wq, host_done, eng_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL hw_finish: got wq=%b hdone=%b edone=%b want 0 1 0", x_wq, host_done, eng_done);
    end
    step();
    n_tests++;
    if (host_done !== 1'b0 || wq_cnt - w0 != 1 || mem[0][5] !== 1'b1) begin
      n_fail++;
      $display("FAIL hw_result: got done=%b strobes=%0d mem=%b want 0 1 1",
               host_done, wq_cnt - w0, mem[0][5]);
    end
    // Read the word back through the host port.
    host_acc = 1'b1; host_we = 1'b0;
    step();
    host_acc = 1'b0;
    n_tests++;
    if (host_done !== 1'b0) begin
      n_fail++; $display("FAIL hr_early: got done=%b want 0", host_done);
    end
    step();
    n_tests++;
    if ({host_done, host_rdata} !== 2'b11) begin
      n_fail++; $display("FAIL hr_data: got done=%b rdata=%b want 1 1", host_done, host_rdata);
    end
    host_req = 1'b0;
    step();
    step();
    n_tests++;
    if ({host_gnt, busy} !== 2'b00) begin
      n_fail++; $display("FAIL hw_release: got gnt=%b busy=%b want 0 0", host_gnt, busy);
    end
  endtask

  task automatic test_eng_read();
    eng_req = 1'b1;
    step();
    eng_acc = 1'b1; eng_we = 1'b1; eng_addr = 10'd1023; eng_sel = 2'd2; eng_wdata = 1'b1;
    step();
    eng_acc = 1'b0;
    step(); step(); step();
    w0 = wq_cnt;
    eng_acc = 1'b1; eng_we = 1'b0;
    step();
    eng_acc = 1'b0;
    n_tests++;
    if ({eng_done, x_wq, x_addr, x_sel} !== {1'b0, 1'b0, 10'd1023, 2'd2}) begin
      n_fail++;
      $display("FAIL er_capture: got done=%b wq=%b addr=%0d sel=%0d want 0 0 1023 2",
               eng_done, x_wq, x_addr, x_sel);
    end
    step();
    n_tests++;
    if ({eng_done, eng_rdata, host_done, x_wq} !== 4'b1100 || wq_cnt != w0) begin
      n_fail++;
      $display("FAIL er_done: got done=%b rdata=%b hdone=%b wq=%b strobes=%0d want 1 1 0 0 0",
               eng_done, eng_rdata, host_done, x_wq, wq_cnt - w0);
    end
    eng_acc = 1'b1; eng_addr = 10'd1022;
    step();
    eng_acc = 1'b0;
    step();
    n_tests++;
    if ({eng_done, eng_rdata, host_rdata} !== 3'b101) begin
      n_fail++;
      $display("FAIL er_zero: got done=%b rdata=%b host_rdata=%b want 1 0 1",
               eng_done, eng_rdata, host_rdata);
    end
    eng_req = 1'b0;
    step();
  endtask

  task automatic test_contention();
    rst = 1'b1; step(); rst = 1'b0;
    host_req = 1'b1; eng_req = 1'b1;
    step();
    n_tests++;
    if ({eng_gnt, host_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL ct_first: got eng=%b host=%b want 1 0", eng_gnt, host_gnt);
    end
    for (int i = 0; i < 63; i++) step();
    n_tests++;
    if (dut.u_starve_ctr.cnt_q !== 7'd64 || host_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL ct_wait: got cnt=%0d hgnt=%b want 64 0", dut.u_starve_ctr.cnt_q, host_gnt);
    end
    eng_req = 1'b0;
    step();
    n_tests++;
    if ({eng_gnt, host_gnt, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL ct_bubble: got eng=%b host=%b busy=%b want 0 0 0", eng_gnt, host_gnt, busy);
    end
    step();
    n_tests++;
    if (host_gnt !== 1'b1 || dut.u_starve_ctr.cnt_q !== 7'd0) begin
      n_fail++;
      $display("FAIL ct_host: got gnt=%b cnt=%0d want 1 0", host_gnt, dut.u_starve_ctr.cnt_q);
    end
`ifdef XARB_STATS_EN
    n_tests++;
    if ({stat_conflicts, stat_eng_gnts, stat_host_gnts} !== {16'd1, 16'd1, 16'd1}) begin
      n_fail++;
      $display("FAIL ct_stats: got conf=%0d eng=%0d host=%0d want 1 1 1",
               stat_conflicts, stat_eng_gnts, stat_host_gnts);
    end
`endif
    host_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    host_req = 1'b1; eng_req = 1'b1;
    step();
    for (int i = 0; i < 70; i++) step();
    n_tests++;
    if (dut.u_starve_ctr.cnt_q !== 7'd64 || eng_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL sv_sat: got cnt=%0d egnt=%b want 64 1", dut.u_starve_ctr.cnt_q, eng_gnt);
    end
    eng_req = 1'b0;
    step();
    eng_req = 1'b1;
    step();
    n_tests++;
    if ({host_gnt, eng_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL sv_win: got host=%b eng=%b want 1 0", host_gnt, eng_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({host_gnt, eng_gnt} !== 2'b10) begin
        n_fail++; $display("FAIL sv_hold: got host=%b eng=%b want 1 0", host_gnt, eng_gnt);
      end
    end
    host_req = 1'b0;
    step();
    step();
    n_tests++;
    if ({host_gnt, eng_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL sv_eng: got host=%b eng=%b want 0 1", host_gnt, eng_gnt);
    end
    eng_req = 1'b0;
    step();
  endtask

  task automatic test_robust();
    // Request dropped while the strobe is high.
    host_req = 1'b1;
    step();
    host_acc = 1'b1; host_we = 1'b1; host_addr = 10'd7; host_sel = 2'd1; host_wdata = 1'b1;
    step();
    host_acc = 1'b0;
    step();
    host_req = 1'b0;
    step();
    n_tests++;
    if ({host_done, host_gnt} !== 2'b11) begin
      n_fail++; $display("FAIL rb_done: got done=%b gnt=%b want 1 1", host_done, host_gnt);
    end
    step();
    step();
    n_tests++;
    if ({host_gnt, busy, host_done} !== 3'b000 || mem[1][7] !== 1'b1) begin
      n_fail++;
      $display("FAIL rb_release: got gnt=%b busy=%b done=%b mem=%b want 0 0 0 1",
               host_gnt, busy, host_done, mem[1][7]);
    end
    // Reset while the strobe is high.
    host_req = 1'b1;
    step();
    host_acc = 1'b1; host_addr = 10'd9;
    step();
    host_acc = 1'b0;
    step();
    n_tests++;
    if (x_wq !== 1'b1) begin
      n_fail++; $display("FAIL rb_strobe: got wq=%b want 1", x_wq);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if ({x_wq, host_gnt, host_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rb_rst: got wq=%b gnt=%b done=%b want 0 0 0", x_wq, host_gnt, host_done);
    end
    rst = 1'b0; host_req = 1'b0;
    step();
    n_tests++;
    if ({host_done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rb_nodone: got done=%b busy=%b want 0 0", host_done, busy);
    end
  endtask

  task automatic test_ignored();
    w0 = wq_cnt;
    host_acc = 1'b1; host_we = 1'b1; host_addr = 10'd3; host_sel = 2'd3; host_wdata = 1'b1;
    step(); step(); step(); step();
    host_acc = 1'b0;
    n_tests++;
    if ({host_done, busy} !== 2'b00 || wq_cnt != w0 || mem[3][3] !== 1'b0) begin
      n_fail++;
      $display("FAIL ig_nognt: got done=%b busy=%b strobes=%0d mem=%b want 0 0 0 0",
               host_done, busy, wq_cnt - w0, mem[3][3]);
    end
    // acc held high through a write must not start a second access.
    eng_req = 1'b1;
    step();
    eng_acc = 1'b1; eng_we = 1'b1; eng_addr = 10'd4; eng_sel = 2'd2; eng_wdata = 1'b1;
    step();
    eng_we = 1'b0;
    step();
    step();
    n_tests++;
    if (eng_done !== 1'b1) begin
      n_fail++; $display("FAIL ig_wdone: got done=%b want 1", eng_done);
    end
    step();
    eng_acc = 1'b0;
    step();
    n_tests++;
    if ({eng_done, busy, eng_gnt} !== 3'b011 || wq_cnt - w0 != 1) begin
      n_fail++;
      $display("FAIL ig_inflight: got done=%b busy=%b gnt=%b strobes=%0d want 0 1 1 1",
               eng_done, busy, eng_gnt, wq_cnt - w0);
    end
    eng_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_eng_read();
    test_contention();
    test_starvation();
    test_robust();
    test_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
